// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared constants, types and the duty-compare helper for the PWM output
// controller.
//   PWM_CNT_W  : width of the period counter and of the duty value
//   NUM_PINS   : number of driven output pins
//   DUTY_FULL  : duty code that forces the waveform permanently high
//   pin_vec_t  : one bit per output pin
// ---------------------------------------------------------------------------
package pwm_pkg;

    localparam int                   PWM_CNT_W = 8;
    localparam int                   NUM_PINS  = 16;
    localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;

    typedef logic [NUM_PINS-1:0] pin_vec_t;

    // A plain "cnt < duty" compare tops out at 255/256 high, so the full
    // code is special-cased to give a true 100% waveform.
    function automatic logic pwm_level(input logic [PWM_CNT_W-1:0] cnt,
                                       input logic [PWM_CNT_W-1:0] duty);
        return (duty == DUTY_FULL) || (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_output_ctrl_if.sv
// ---------------------------------------------------------------------------
// pwm_output_ctrl_if
// Bundles the configuration registers coming from the SPI register block and
// the pin-side outputs of the PWM controller.
//   master : register-block side (drives configuration, observes outputs)
//   slave  : controller side (consumes configuration, drives outputs)
// Signals:
//   en_out_lo/hi  output enables for pins 7:0 / 15:8
//   en_pwm_lo/hi  PWM select for pins 7:0 / 15:8
//   duty          shared duty cycle
//   pins_out      registered pin drive
//   period_start  one-clock pulse when the period counter wraps
//   pwm_raw       registered shared PWM waveform
// ---------------------------------------------------------------------------
interface pwm_output_ctrl_if;
    import pwm_pkg::*;

    logic [7:0] en_out_lo;
    logic [7:0] en_out_hi;
    logic [7:0] en_pwm_lo;
    logic [7:0] en_pwm_hi;
    logic [7:0] duty;
    pin_vec_t   pins_out;
    logic       period_start;
    logic       pwm_raw;

    modport master (
        output en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, duty,
        input  pins_out, period_start, pwm_raw
    );

    modport slave (
        input  en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, duty,
        output pins_out, period_start, pwm_raw
    );

endinterface

// File: rtl/pwm_prescaler.sv
// ---------------------------------------------------------------------------
// pwm_prescaler
// Divides the system clock into PWM counter steps: counts 0..CLK_DIV-1 and
// asserts tick for the clock in which it sits at CLK_DIV-1.
// Parameters:
//   CLK_DIV : system clocks per tick, 1..65535 (1 gives tick every clock)
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset, restarts a full prescale interval
//   tick : high for one clock every CLK_DIV clocks
// ---------------------------------------------------------------------------
module pwm_prescaler #(
    parameter int CLK_DIV = 3000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    // $clog2(1) is 0, so keep at least one bit of counter.
    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             w_last;

    assign w_last = (r_div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_last) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    assign tick = w_last;

endmodule

// File: rtl/pwm_output_ctrl.sv
// ---------------------------------------------------------------------------
// pwm_output_ctrl
// Drives 16 output pins, each statically low, statically high, or following a
// shared PWM waveform. An 8-bit period counter advances once per prescaler
// tick; the waveform is high while the counter is below the duty value.
//
// Build option:
//   PWM_SHADOW_EN defined   : enables and duty are captured into shadow
//                             registers at each period wrap (and once on the
//                             first clock after reset), so updates land only
//                             on period boundaries.
//   PWM_SHADOW_EN undefined : configuration feeds the compare and pin mux
//                             directly; changes reach the pins one clock later.
//
// Parameters:
//   CLK_DIV : system clocks per counter step (period = 256*CLK_DIV clocks)
// Ports:
//   clk    : system clock
//   rst    : synchronous active-high reset
//   io_bus : configuration in / pins_out, period_start, pwm_raw out
// ---------------------------------------------------------------------------
module pwm_output_ctrl
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = 3000
) (
    input  logic                clk,
    input  logic                rst,
    pwm_output_ctrl_if.slave    io_bus
);

    logic                 w_tick;
    logic                 w_wrap;
    logic [PWM_CNT_W-1:0] r_cnt;

    pin_vec_t             w_out_en;
    pin_vec_t             w_pwm_en;
    logic [PWM_CNT_W-1:0] w_duty;
    logic                 w_pwm;
    pin_vec_t             w_pins;

    pin_vec_t             r_pins;
    logic                 r_period_start;
    logic                 r_pwm_raw;

    pwm_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // Period counter, free-running modulo 256 on prescaler ticks.
    assign w_wrap = w_tick && (r_cnt == {PWM_CNT_W{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= r_cnt + PWM_CNT_W'(1);
        end
    end

`ifdef PWM_SHADOW_EN
    pin_vec_t             r_out_en;
    pin_vec_t             r_pwm_en;
    logic [PWM_CNT_W-1:0] r_duty;
    logic                 r_first;

    // r_first is held high through reset so the configuration present at
    // start-up is captured on the first clock after release instead of
    // waiting a whole period. Capturing on the wrap edge means the cnt=0
    // cycle already runs with the new values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_en <= '0;
            r_pwm_en <= '0;
            r_duty   <= '0;
            r_first  <= 1'b1;
        end else begin
            r_first <= 1'b0;
            if (w_wrap || r_first) begin
                r_out_en <= {io_bus.en_out_hi, io_bus.en_out_lo};
                r_pwm_en <= {io_bus.en_pwm_hi, io_bus.en_pwm_lo};
                r_duty   <= io_bus.duty;
            end
        end
    end

    assign w_out_en = r_out_en;
    assign w_pwm_en = r_pwm_en;
    assign w_duty   = r_duty;
`else
    assign w_out_en = {io_bus.en_out_hi, io_bus.en_out_lo};
    assign w_pwm_en = {io_bus.en_pwm_hi, io_bus.en_pwm_lo};
    assign w_duty   = io_bus.duty;
`endif

    assign w_pwm = pwm_level(r_cnt, w_duty);

    // Per-pin select: disabled -> low, enabled -> high, or the PWM waveform
    // when PWM is selected.
    for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_pin_mux
        assign w_pins[gi] = w_out_en[gi] & (~w_pwm_en[gi] | w_pwm);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pins         <= '0;
            r_period_start <= 1'b0;
            r_pwm_raw      <= 1'b0;
        end else begin
            r_pins         <= w_pins;
            r_period_start <= w_wrap;
            r_pwm_raw      <= w_pwm;
        end
    end

    assign io_bus.pins_out     = r_pins;
    assign io_bus.period_start = r_period_start;
    assign io_bus.pwm_raw      = r_pwm_raw;

endmodule

// File: tb/tb_pwm_output_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pwm_output_ctrl
// Directed bench for pwm_output_ctrl: one instance at CLK_DIV=4 and one at
// CLK_DIV=1. Expected values are hand-derived from the period arithmetic.
// Outputs are sampled on the falling edge; "m" counts falling edges after the
// falling edge on which period_start is seen (m=0), so the pin value at m
// reflects the counter value floor((m-1)/CLK_DIV) of the new period.
// ---------------------------------------------------------------------------
module tb_pwm_output_ctrl;
    import pwm_pkg::*;

    logic clk;
    logic rst;
    logic rst1;

    int n_checks;
    int n_fail;

    pwm_output_ctrl_if u_if ();
    pwm_output_ctrl_if u_if1 ();

    pwm_output_ctrl #(.CLK_DIV(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (u_if)
    );

    pwm_output_ctrl #(.CLK_DIV(1)) dut1 (
        .clk    (clk),
        .rst    (rst1),
        .io_bus (u_if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Count falling edges until period_start is seen; k=-1 on timeout.
    task automatic wait_ps(input bit sel1, input int limit, output int k);
        k = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if ((sel1 ? u_if1.period_start : u_if.period_start) === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    // Observe one full period of dut (m=1..1024), starting at a period_start
    // sample. Optionally changes duty right after sampling at m==chg_m.
    task automatic run_period(input int chg_m, input logic [7:0] chg_duty,
                              output int highs, output int first, output int last,
                              output int ps_seen, output int raw_highs,
                              output logic [15:0] others);
        highs = 0; first = -1; last = -1; ps_seen = 0; raw_highs = 0; others = '0;
        for (int m = 1; m <= 1024; m++) begin
            @(negedge clk);
            if (u_if.pins_out[0] === 1'b1) begin
                highs++;
                if (first < 0) first = m;
                last = m;
            end
            if (u_if.pwm_raw === 1'b1) raw_highs++;
            if (u_if.period_start === 1'b1) ps_seen++;
            others = others | (u_if.pins_out & 16'hFFFE);
            if (m == chg_m) u_if.duty = chg_duty;
        end
    endtask

    initial begin
        int k, highs, first, last, ps_seen, raw_highs;
        logic [15:0] others;

        n_checks = 0;
        n_fail   = 0;

        rst  = 1'b1;
        rst1 = 1'b1;
        u_if.en_out_lo  = 8'hFF; u_if.en_out_hi  = 8'hFF;
        u_if.en_pwm_lo  = 8'h00; u_if.en_pwm_hi  = 8'h00;
        u_if.duty       = 8'h00;
        u_if1.en_out_lo = 8'h01; u_if1.en_out_hi = 8'h00;
        u_if1.en_pwm_lo = 8'h01; u_if1.en_pwm_hi = 8'h00;
        u_if1.duty      = 8'h80;

        repeat (3) @(negedge clk);
        check("rst_pins", u_if.pins_out, 0);
        check("rst_ps", u_if.period_start, 0);
        check("rst_raw", u_if.pwm_raw, 0);
        check("rst1_pins", u_if1.pins_out, 0);

        // Start-up: static-high on all pins.
        rst = 1'b0;
        @(negedge clk);
`ifdef PWM_SHADOW_EN
        check("start_1clk", u_if.pins_out, 16'h0000);
`else
        check("start_1clk", u_if.pins_out, 16'hFFFF);
`endif
        @(negedge clk);
        check("start_2clk", u_if.pins_out, 16'hFFFF);
        check("start_raw", u_if.pwm_raw, 0);
        wait_ps(1'b0, 1100, k);
        check("start_ps_len", k, 1022);

        // Mixed mux: 15:12 pwm(duty 0)=low, 7:4 static high, rest disabled.
        u_if.en_out_lo = 8'hF0; u_if.en_out_hi = 8'hF0;
        u_if.en_pwm_lo = 8'h00; u_if.en_pwm_hi = 8'hFF;
        run_period(-1, 8'h00, highs, first, last, ps_seen, raw_highs, others);
        check("mux_settle_ps", u_if.period_start, 1);
        repeat (2) @(negedge clk);
        check("mux_d00", u_if.pins_out, 16'h00F0);
        wait_ps(1'b0, 1100, k);
        check("mux_ps_len", k, 1022);

        // Pin 0 at duty 0x40.
        u_if.en_out_lo = 8'h01; u_if.en_out_hi = 8'h00;
        u_if.en_pwm_lo = 8'h01; u_if.en_pwm_hi = 8'h00;
        u_if.duty      = 8'h40;
        run_period(-1, 8'h00, highs, first, last, ps_seen, raw_highs, others);
        run_period(1023, 8'h00, highs, first, last, ps_seen, raw_highs, others);
        check("d40_highs", highs, 256);
        check("d40_first", first, 1);
        check("d40_last", last, 256);
        check("d40_raw", raw_highs, 256);
        check("d40_others", others, 0);
        check("d40_ps_cnt", ps_seen, 1);
        check("d40_ps_end", u_if.period_start, 1);

        // duty 0x00 period; 0xFF lands on the wrap edge.
        run_period(1023, 8'hFF, highs, first, last, ps_seen, raw_highs, others);
`ifdef PWM_SHADOW_EN
        check("d00_highs", highs, 0);
`else
        check("d00_highs", highs, 1);
`endif
        check("d00_ps_cnt", ps_seen, 1);

        // duty 0xFF period; 0x40 lands on the wrap edge.
        run_period(1023, 8'h40, highs, first, last, ps_seen, raw_highs, others);
`ifdef PWM_SHADOW_EN
        check("dff_highs", highs, 1024);
`else
        check("dff_highs", highs, 1023);
`endif
        check("dff_first", first, 1);

        // duty 0x40 -> 0xC0 written while cnt=0x80.
        run_period(512, 8'hC0, highs, first, last, ps_seen, raw_highs, others);
`ifdef PWM_SHADOW_EN
        check("mid_highs", highs, 256);
        check("mid_last", last, 256);
`else
        check("mid_highs", highs, 512);
        check("mid_last", last, 768);
`endif
        check("mid_ps_end", u_if.period_start, 1);
        run_period(-1, 8'h00, highs, first, last, ps_seen, raw_highs, others);
        check("dc0_highs", highs, 768);
        check("dc0_first", first, 1);
        check("dc0_last", last, 768);

        // One-clock reset while cnt=0x55 (pin 0 high at duty 0xC0).
        repeat (341) @(negedge clk);
        check("pre_rst_pin0", u_if.pins_out, 16'h0001);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_pins", u_if.pins_out, 0);
        check("midrst_raw", u_if.pwm_raw, 0);
        check("midrst_ps", u_if.period_start, 0);
        rst = 1'b0;
        wait_ps(1'b0, 1100, k);
        check("midrst_ps_len", k, 1024);

        // CLK_DIV=1 instance, duty 0x80.
        rst1 = 1'b0;
        wait_ps(1'b1, 300, k);
        check("div1_first_ps", k, 256);
        highs = 0; ps_seen = 0;
        for (int m = 1; m <= 256; m++) begin
            @(negedge clk);
            if (u_if1.pins_out[0] === 1'b1) highs++;
            if (u_if1.period_start === 1'b1) ps_seen++;
        end
        check("div1_highs", highs, 128);
        check("div1_ps_cnt", ps_seen, 1);
        check("div1_ps_end", u_if1.period_start, 1);
        wait_ps(1'b1, 300, k);
        check("div1_ps_len", k, 256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_output_ctrl.md
Name: pwm_output_ctrl

Overview:
- Consumes the five SPI-written configuration registers (output enables, PWM enables, duty cycle) and drives 16 output pins.
- Each pin is one of three things: static low, static high, or a shared PWM waveform.
- Contains a clock prescaler, an 8-bit period counter and duty-compare logic.
- Configuration is double-buffered so that SPI writes take effect only at period boundaries.
- Sits between the SPI register block and the chip output pins.

Parameters:
- CLK_DIV, 3000, system clocks per PWM counter step. Legal range 1..65535. Period = 256*CLK_DIV clocks.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- en_out_lo  input  8  output enable, pins 7:0.
- en_out_hi  input  8  output enable, pins 15:8.
- en_pwm_lo  input  8  PWM select, pins 7:0.
- en_pwm_hi  input  8  PWM select, pins 15:8.
- duty  input  8  shared duty cycle (0x00 = 0%, 0xFF = 100%).
- pins_out  output  16  registered pin drive.
- period_start  output  1  one-clock pulse when the period counter wraps 255->0.
- pwm_raw  output  1  registered shared PWM waveform, for debug.

Behaviour:
- Reset (rst=1 at a clk edge) clears:
  - prescaler, period counter (cnt), shadow registers;
  - pins_out=0, period_start=0, pwm_raw=0.
- Reset asserted mid-period aborts the period immediately. After release, cnt restarts at 0 with a full CLK_DIV prescale.
- Prescaler:
  - Counts 0..CLK_DIV-1 and generates tick when it equals CLK_DIV-1, then wraps to 0.
  - Counter width is $clog2(CLK_DIV), minimum 1.
  - CLK_DIV=1 gives tick every clock.
- Period counter cnt [7:0]:
  - Increments on tick and wraps 255->0 naturally (modulo 256).
  - wrap = tick && cnt==255.
- Shadow load:
  - On wrap, the shadow registers capture en_out_{lo,hi}, en_pwm_{lo,hi} and duty. The new cnt=0 cycle uses the new values.
  - Also loaded once in the first clock after reset release, so that configuration present at start-up applies without waiting a full period.
- PWM compare, evaluated combinationally on the current cnt and shadow duty:
  - pwm = 1 if shadow duty==0xFF.
  - Otherwise pwm = (cnt < shadow duty).
  - duty=0x00 gives constant 0. duty=0x80 gives 128 of 256 steps high.
- Pin mux for each i in 0..15:
  - out_en[i]=0 -> pin low.
  - out_en[i]=1 and pwm_en[i]=0 -> pin high.
  - out_en[i]=1 and pwm_en[i]=1 -> pin = pwm.
- Registering and latency:
  - pins_out and pwm_raw are registered, giving 1 clock of latency from a cnt change to the pin.
  - period_start is registered from wrap and pulses in the same clock that cnt becomes 0.
- Simultaneous events:
  - A config input change in the same clock as wrap is captured, because sampling uses the input value present at that edge.
  - Changes at any other time are ignored until the next wrap.
  - Inputs are assumed synchronous to clk; they already come from clk-domain registers.
- No other state machine; the block free-runs.

Optional Feature:
- Macro: PWM_SHADOW_EN.
- Defined: behaviour as above. Shadow registers load only on wrap and on the first clock after reset; glitch-free duty updates.
- Not defined:
  - No shadow registers; enables and duty feed the compare and mux directly.
  - A change is visible on pins_out 1 clock after the input changes.
  - period_start is still generated.

Decomposition:
- Shared package pwm_pkg:
  - PWM_CNT_W=8;
  - NUM_PINS=16;
  - DUTY_FULL=8'hFF;
  - typedef pin_vec_t (logic [NUM_PINS-1:0]).
- One natural sub-module: pwm_prescaler (parameter CLK_DIV; ports clk, rst, tick). The top instantiates it plus the counter, shadow and mux logic.

Test Plan (CLK_DIV=4 unless stated):
- Reset then en_out=0xFFFF, en_pwm=0x0000 -> pins_out=0xFFFF two clocks after reset release; period_start first pulses 1024 clocks after cnt starts.
- en_out_lo=0x01, en_pwm_lo=0x01, duty=0x40 -> pin0 high for exactly 64*4=256 clocks of every 1024-clock period, low for 768; other pins 0.
- duty=0x00 then duty=0xFF, with pin0 PWM-enabled -> pin0 constant 0 for a full period, then constant 1 for a full period, with no 1-clock glitch at wrap.
- With PWM_SHADOW_EN: change duty 0x40->0xC0 at cnt=0x80 -> current period finishes at 0x40 width; next period (after period_start) is 192 steps high.
- Without PWM_SHADOW_EN: the same stimulus -> pin0 goes high again 1 clock after the change (cnt=0x80 < 0xC0).
- Assert rst for 1 clock at cnt=0x55 -> next clock pins_out=0 and cnt=0; after release, period_start arrives after a full 256*CLK_DIV clocks. Then repeat the period-length check with CLK_DIV=1: period_start every 256 clocks.
